// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end of the pipelined 8-bit core. It owns the program
// counter, selects the next PC, and holds the IF/ID pipeline register that
// feeds the decode stage. Fetching stops on a halt-flagged word and resumes
// only on a redirect or reset.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   inst_addr       instruction memory address (registered PC)
//   inst_data       instruction word read combinationally at inst_addr
//   inst_halt       memory flags inst_data as a halt instruction
//   if_id_wr        1 = advance, 0 = stall (hold PC, IF/ID, state, count)
//   branch_taken / branch_target   branch redirect (lowest priority)
//   jmp / jmp_target               direct jump redirect
//   ret / ret_target               stack return redirect (highest priority)
//   id_pc_plus1     IF/ID: fetched PC + 1 (0 for a bubble)
//   id_instruction  IF/ID: fetched word, NOP_WORD for a bubble
//   id_valid        IF/ID holds a real instruction
//   halted          fetch stopped on a halt instruction
//   fetch_count     number of valid words written into IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned                PC_WIDTH   = 12,
    parameter int unsigned                INST_WIDTH = 19,
    parameter logic [PC_WIDTH-1:0]        RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0]      NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   inst_addr,
    input  logic [INST_WIDTH-1:0] inst_data,
    input  logic                  inst_halt,
    input  logic                  if_id_wr,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  jmp,
    input  logic [PC_WIDTH-1:0]   jmp_target,
    input  logic                  ret,
    input  logic [PC_WIDTH-1:0]   ret_target,
    output logic [PC_WIDTH-1:0]   id_pc_plus1,
    output logic [INST_WIDTH-1:0] id_instruction,
    output logic                  id_valid,
    output logic                  halted,
    output logic [15:0]           fetch_count
);

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);
    localparam logic [15:0]         COUNT_ONE = 16'd1;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [PC_WIDTH-1:0]     id_pc_plus1_q, id_pc_plus1_d;
    logic [INST_WIDTH-1:0]   id_instruction_q, id_instruction_d;
    logic                    id_valid_q, id_valid_d;
    logic [15:0]             fetch_count_q, fetch_count_d;

    logic                    redirect;
    logic [PC_WIDTH-1:0]     redirect_target;
    logic [PC_WIDTH-1:0]     pc_plus1;

    assign redirect = ret | jmp | branch_taken;
    assign pc_plus1 = pc_q + PC_ONE;

    always_comb begin
        redirect_target = branch_target;
        if (ret) begin
            redirect_target = ret_target;
        end else if (jmp) begin
            redirect_target = jmp_target;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        id_pc_plus1_d    = id_pc_plus1_q;
        id_instruction_d = id_instruction_q;
        id_valid_d       = id_valid_q;
        fetch_count_d    = fetch_count_q;

        if (redirect) begin
            // A redirect beats a stall and any same-cycle halt: the word at
            // the old PC is wrong-path, so it never reaches IF/ID.
            pc_d             = redirect_target;
            id_pc_plus1_d    = '0;
            id_instruction_d = NOP_WORD;
            id_valid_d       = 1'b0;
            state_d          = ST_FETCH;
        end else if (if_id_wr) begin
            unique case (state_q)
                ST_FETCH: begin
                    id_pc_plus1_d    = pc_plus1;
                    id_instruction_d = inst_data;
                    id_valid_d       = 1'b1;
                    fetch_count_d    = fetch_count_q + COUNT_ONE;
                    if (inst_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
                ST_HALTED: begin
                    id_pc_plus1_d    = '0;
                    id_instruction_d = NOP_WORD;
                    id_valid_d       = 1'b0;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_FETCH;
            pc_q             <= RESET_PC;
            id_pc_plus1_q    <= '0;
            id_instruction_q <= NOP_WORD;
            id_valid_q       <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            id_pc_plus1_q    <= id_pc_plus1_d;
            id_instruction_q <= id_instruction_d;
            id_valid_q       <= id_valid_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign inst_addr      = pc_q;
    assign id_pc_plus1    = id_pc_plus1_q;
    assign id_instruction = id_instruction_q;
    assign id_valid       = id_valid_q;
    assign halted         = (state_q == ST_HALTED);
    assign fetch_count    = fetch_count_q;

endmodule
